// File: rtl/row_store_pkg.sv
// Shared row layout constants and responder FSM states for the row store.
// Rows are 40 words long and sit on a 64-word address stride.
package row_store_pkg;

  localparam int WORDS_PER_ROW = 40;
  localparam int ROW_STRIDE    = 64;
  localparam int WORD_BITS     = 16;
  localparam int ADDR_WIDTH    = 24;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_ACK,
    WR_ACK,
    GAP,
    REFRESH
  } state_t;

endpackage

// File: rtl/row_store_ram.sv
// Single-port synchronous RAM, registered read, one access per cycle.
// Latency 1 cycle from address to q; no backpressure, and the array is never reset.
module row_store_ram #(
  parameter int ADDR_BITS = 15,
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] q
);

  logic [WORD_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/row_store_responder.sv
// Word-serial read/write/refresh responder backed by block RAM; write ack 1 cycle, read ack 2 cycles after acceptance.
// The initiator holds read/write until each ack; refresh is a stall and pulses are merged while pending.
module row_store_responder
  import row_store_pkg::*;
#(
  parameter int ADDR_BITS      = 15,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic                  readAcknowledge,
  output logic [WORD_BITS-1:0]  readData,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [WORD_BITS-1:0]  writeData,
  output logic                  writeAcknowledge,
  input  logic                  refresh,
  output logic                  busy,
  output logic                  rangeError
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  state_t               state, state_nxt;
  logic                 refresh_pending;
  logic [CNT_W-1:0]     refresh_cnt;
  logic                 rd_oor;
  logic                 enter_refresh, accept_wr, accept_rd;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [WORD_BITS-1:0] ram_q;
  logic                 wr_oor, rd_oor_now;

  assign wr_oor     = |writeAddress[ADDR_WIDTH-1:ADDR_BITS];
  assign rd_oor_now = |readAddress[ADDR_WIDTH-1:ADDR_BITS];

  assign readAcknowledge  = (state == RD_ACK);
  assign writeAcknowledge = (state == WR_ACK);
  assign busy             = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    ram_we        = 1'b0;
    ram_addr      = readAddress[ADDR_BITS-1:0];
    accept_wr     = 1'b0;
    accept_rd     = 1'b0;
    enter_refresh = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_pending) begin
          enter_refresh = 1'b1;
          state_nxt     = REFRESH;
        end else if (write) begin
          accept_wr = 1'b1;
          ram_addr  = writeAddress[ADDR_BITS-1:0];
          ram_we    = !wr_oor;
          state_nxt = WR_ACK;
        end else if (read) begin
          accept_rd = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = RD_ACK;
      RD_ACK:  state_nxt = GAP;
      WR_ACK:  state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      REFRESH: if (refresh_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      refresh_pending <= 1'b0;
      refresh_cnt     <= '0;
      rd_oor          <= 1'b0;
      readData        <= '0;
      rangeError      <= 1'b0;
    end else begin
      state <= state_nxt;
      // A pulse landing on the entry cycle is absorbed by the refresh being started.
      if (enter_refresh)  refresh_pending <= 1'b0;
      else if (refresh)   refresh_pending <= 1'b1;
      if (enter_refresh)
        refresh_cnt <= CNT_W'(REFRESH_CYCLES - 1);
      else if (state == REFRESH && refresh_cnt != '0)
        refresh_cnt <= refresh_cnt - CNT_W'(1);
      if (accept_rd) rd_oor <= rd_oor_now;
      if (state == RD_WAIT) readData <= rd_oor ? '0 : ram_q;
      if ((accept_wr && wr_oor) || (accept_rd && rd_oor_now)) rangeError <= 1'b1;
    end
  end

  row_store_ram #(
    .ADDR_BITS(ADDR_BITS),
    .WORD_BITS(WORD_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(writeData),
    .q    (ram_q)
  );

endmodule
